// File: rtl/ahblite_slave_mux_param.sv
// AHB-Lite data-phase response multiplexer for NPORT slaves with a built-in
// default slave that answers decode misses and multi-hits with a two-cycle ERROR.
module ahblite_slave_mux_param #(
    parameter int NPORT            = 6,
    parameter int DW               = 32,
    parameter int DEFAULT_SLAVE_EN = 1,
    parameter int CNTW             = 8
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HREADY,
    input  logic [1:0]          HTRANS,
    input  logic [NPORT-1:0]    HSEL_VEC,
    input  logic [NPORT-1:0]    HREADYOUT_VEC,
    input  logic [NPORT-1:0]    HRESP_VEC,
    input  logic [NPORT*DW-1:0] HRDATA_BUS,
    input  logic                ERR_CLR,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [DW-1:0]       HRDATA,
    output logic [CNTW-1:0]     ERR_CNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } state_t;

    localparam logic [NPORT-1:0] ONE = NPORT'(1);

    state_t            state_q, state_d;
    logic [NPORT-1:0]  sel_q, sel_d;
    logic              hit_q, hit_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic              sel_onehot;
    logic              miss;
    logic              inc;
    logic              dflt_rdy;
    logic              dflt_rsp;
    logic [DW-1:0]     rd_terms [NPORT];
    logic [DW-1:0]     rd_or;
    logic              unused_htrans0;

    // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    assign unused_htrans0 = HTRANS[0];

    assign sel_onehot = (HSEL_VEC != '0) && ((HSEL_VEC & (HSEL_VEC - ONE)) == '0);
    assign miss       = !sel_onehot && HTRANS[1] && (DEFAULT_SLAVE_EN != 0);

    // Address phase is only accepted while the bus is ready.
    assign sel_d = HREADY ? HSEL_VEC   : sel_q;
    assign hit_d = HREADY ? sel_onehot : hit_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (HREADY && miss) state_d = ERR1;
            ERR1:    state_d = ERR2;
            ERR2:    state_d = (HREADY && miss) ? ERR1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dflt_rdy = 1'b1;
        dflt_rsp = 1'b0;
        case (state_q)
            ERR1: begin
                dflt_rdy = 1'b0;
                dflt_rsp = 1'b1;
            end
            ERR2: begin
                dflt_rdy = 1'b1;
                dflt_rsp = 1'b1;
            end
            default: begin
                dflt_rdy = 1'b1;
                dflt_rsp = 1'b0;
            end
        endcase
    end

    // ERR1 is only ever entered from IDLE or ERR2, so this marks each entry.
    assign inc = (state_d == ERR1);

    always_comb begin
        cnt_d = cnt_q;
        if (ERR_CLR) begin
            cnt_d = inc ? CNTW'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd
            assign rd_terms[gi] = {DW{sel_q[gi]}} & HRDATA_BUS[gi*DW +: DW];
        end
    endgenerate

    always_comb begin
        rd_or = '0;
        for (int i = 0; i < NPORT; i++) begin
            rd_or = rd_or | rd_terms[i];
        end
    end

    // hit_q guarantees sel_q is one-hot, so an AND-OR mux is exact.
    always_comb begin
        if (hit_q) begin
            HREADYOUT = |(sel_q & HREADYOUT_VEC);
            HRESP     = |(sel_q & HRESP_VEC);
            HRDATA    = rd_or;
        end else begin
            HREADYOUT = dflt_rdy;
            HRESP     = dflt_rsp;
            HRDATA    = '0;
        end
    end

    assign ERR_CNT = cnt_q;

endmodule

// File: doc/ahblite_slave_mux_param.md
Name: ahblite_slave_mux_param

Overview:
Parametrised N-port AHB-Lite data-phase response multiplexer with a built-in default slave.
- Registers the address-phase slave select when HREADY is high.
- Routes the selected slave's HREADYOUT/HRESP/HRDATA back to the master during the data phase.
- Issues a two-cycle AHB ERROR response for any active transfer that hits no slave or more than one slave.
- Counts decode errors in a saturating status counter.
- Sits between the address decoder and the master in the AHB-Lite interconnect. It is the generalised successor of the fixed six-port mux.

Parameters:
NPORT, 6, number of slave ports (1..32)
DW, 32, read data width
DEFAULT_SLAVE_EN, 1, 1 = ERROR response on decode miss or multi-hit; 0 = zero-wait OKAY with zero data
CNTW, 8, decode-error counter width

Ports:
HCLK  input  1  clock
HRESETn  input  1  asynchronous active-low reset
HREADY  input  1  bus-wide HREADY (fed back from HREADYOUT)
HTRANS  input  2  master transfer type, address phase
HSEL_VEC  input  NPORT  decoder selects; bit i = port i
HREADYOUT_VEC  input  NPORT  slave HREADYOUT; bit i = port i
HRESP_VEC  input  NPORT  slave HRESP; bit i = port i
HRDATA_BUS  input  NPORT*DW  slave read data; port i at [i*DW +: DW]
ERR_CLR  input  1  synchronous clear of ERR_CNT
HREADYOUT  output  1  muxed ready to master
HRESP  output  1  muxed response to master
HRDATA  output  DW  muxed read data
ERR_CNT  output  CNTW  saturating decode-error count

Behaviour:
Clock and reset:
- One clock, HCLK.
- Reset is asynchronous and active-low on HRESETn. All state is cleared on reset.

Reset values:
- sel_q = 0, dflt_q = 0, FSM = IDLE, ERR_CNT = 0.
- Outputs: HREADYOUT = 1, HRESP = 0, HRDATA = 0.

Address-phase capture (only when HREADY = 1):
- sel_q <= HSEL_VEC.
- active = HTRANS[1] (NONSEQ or SEQ).
- miss = (HSEL_VEC is not one-hot) && active && DEFAULT_SLAVE_EN. "Not one-hot" includes the all-zero case.
- When HREADY = 0, sel_q and all FSM inputs hold.

Data-phase routing (combinational from state):
- sel_q one-hot at bit i: HREADYOUT = HREADYOUT_VEC[i], HRESP = HRESP_VEC[i], HRDATA = HRDATA_BUS[i*DW +: DW].
- Otherwise: HRDATA = 0; HREADYOUT and HRESP are driven by the FSM.

Default-slave FSM:
- IDLE: HREADYOUT = 1, HRESP = 0 when sel_q is not one-hot.
  - Goes to ERR1 when HREADY = 1 and miss = 1.
- ERR1: HREADYOUT = 0, HRESP = 1. Always goes to ERR2 on the next cycle.
- ERR2: HREADYOUT = 1, HRESP = 1.
  - If HREADY = 1 and miss = 1 (a new missed transfer): go to ERR1.
  - Otherwise: go to IDLE.
- Multi-hot sel_q with DEFAULT_SLAVE_EN = 1 is routed by the FSM, not by any port. Such transfers never reach a slave response.
- With DEFAULT_SLAVE_EN = 0 the FSM stays in IDLE. Miss and multi-hit transfers complete zero-wait OKAY with HRDATA = 0.
- IDLE/BUSY transfers to an unmapped address give zero-wait OKAY, never ERROR.

Error counter:
- ERR_CNT increments by 1 on each transition into ERR1.
- Saturates at 2^CNTW-1.
- ERR_CLR = 1 clears the counter to 0.
- ERR_CLR together with an increment in the same cycle: counter loads 1.

Boundary cases:
- NPORT = 1: one-hot reduces to HSEL_VEC[0] = 1.
- Reset asserted during ERR1 or ERR2: immediately IDLE with HREADYOUT = 1. No residual error cycle after reset release.
- A slave wait state (HREADYOUT_VEC[i] = 0) holds sel_q because HREADY = 0. The next address is sampled only on the slave's ready cycle.

Latency:
- Zero added cycles for mapped slaves.
- Exactly 2 data-phase cycles for decode errors.

Test Plan:
1. Reset, then NONSEQ with HSEL_VEC = 6'b000100 and slave 2 returning 0xA5A5_0002 with one wait state -> HREADYOUT 0 then 1; HRDATA = 0xA5A5_0002 on the ready cycle; HRESP = 0.
2. NONSEQ with HSEL_VEC = 0 -> next cycle HREADYOUT = 0, HRESP = 1; following cycle HREADYOUT = 1, HRESP = 1; ERR_CNT = 1.
3. NONSEQ with HSEL_VEC = 6'b010010 -> same two-cycle ERROR; slave 1 and slave 4 responses are ignored; ERR_CNT increments.
4. Back-to-back missed NONSEQ sampled in ERR2 -> ERR1/ERR2 repeats with no IDLE gap; ERR_CNT += 2 total. IDLE HTRANS with HSEL_VEC = 0 -> zero-wait OKAY, no count.
5. CNTW = 2 with five misses -> ERR_CNT saturates at 3. ERR_CLR coincident with a miss -> ERR_CNT = 1.
6. HRESETn low during ERR1 -> HREADYOUT = 1, HRESP = 0, ERR_CNT = 0 asynchronously. Repeat test 2 with DEFAULT_SLAVE_EN = 0 -> zero-wait OKAY, HRDATA = 0.
